key_debouncer: RTL and testbench
================================

KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable synchronized cycles needed to accept a level change; legal range >= 1.
REQ-002 Parameter REPEAT_DELAY, default 25000000, cycles a key must stay held before the first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 5000000, cycles between subsequent auto-repeat pulses; legal range >= 1.
REQ-004 clk  input  1  system clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 key_n  input  1  raw asynchronous pushbutton, active-low, bouncy.
REQ-007 press  output  1  debounced key level, active-high.
REQ-008 press_pulse  output  1  one-cycle strobe on each accepted press (and each auto-repeat when enabled).
REQ-009 release_pulse  output  1  one-cycle strobe on each accepted release.

Function
REQ-010 key_n SHALL pass through a 2-flop synchronizer and be inverted; raw_s denotes the active-high synchronized key.
REQ-011 FSM states SHALL be RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
REQ-012 RELEASED: raw_s=1 -> PRESS_PEND with stability counter cleared to 0; otherwise stay.
REQ-013 PRESS_PEND: raw_s=0 -> RELEASED (glitch rejected, no pulse); raw_s=1 and counter=DEBOUNCE_CYCLES-1 -> PRESSED; otherwise counter increments.
REQ-014 PRESSED: raw_s=0 -> RELEASE_PEND with counter cleared; otherwise stay.
REQ-015 RELEASE_PEND: raw_s=1 -> PRESSED (no pulse); raw_s=0 and counter=DEBOUNCE_CYCLES-1 -> RELEASED; otherwise counter increments.
REQ-016 Stability counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL never wrap.
REQ-017 press SHALL be 1 exactly when state is PRESSED or RELEASE_PEND.
REQ-018 press_pulse SHALL be 1 for exactly the first cycle after a PRESS_PEND->PRESSED transition; release_pulse for exactly the first cycle after a RELEASE_PEND->RELEASED transition.
REQ-019 Latency: if edge N is the first edge sampling key_n=0 and key_n stays low, press and press_pulse SHALL rise after edge N+DEBOUNCE_CYCLES+2; release latency is symmetric.
REQ-020 Any raw_s excursion shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change on any output.
REQ-021 press_pulse and release_pulse SHALL never be 1 in the same cycle.

Reset
REQ-022 rst=1 SHALL force state RELEASED, both synchronizer flops to 0 (released), all counters to 0, and press, press_pulse, release_pulse to 0 on the next edge.
REQ-023 Reset asserted mid-debounce or while PRESSED SHALL abort without emitting release_pulse.
REQ-024 A key held through reset deassertion SHALL be debounced from scratch and produce one press_pulse per REQ-019.

Configuration
REQ-025 Macro KEY_DEBOUNCER_REPEAT_EN SHALL compile the auto-repeat feature in or out.
REQ-026 With KEY_DEBOUNCER_REPEAT_EN defined: a repeat counter SHALL clear on entry to PRESSED from PRESS_PEND, count while in PRESSED, freeze in RELEASE_PEND, and clear in RELEASED; press_pulse SHALL additionally fire for one cycle REPEAT_DELAY cycles after the initial press_pulse, then every REPEAT_PERIOD cycles while held.
REQ-027 Without the macro: no repeat counter SHALL exist; REPEAT_DELAY and REPEAT_PERIOD are ignored; exactly one press_pulse per accepted press.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-028 Reset, then key_n=0 held from edge 10 -> press and press_pulse rise after edge 16; press_pulse low after edge 17; press stays 1.
REQ-029 Bounce: key_n low 3 cycles, high 1, low 2, high -> press, press_pulse, release_pulse stay 0 throughout.
REQ-030 Held press then key_n=1 held from edge 40 -> release_pulse high for one cycle after edge 46; press falls after edge 46.
REQ-031 While PRESSED, key_n high 2 cycles then low -> press stays 1, no release_pulse, no extra press_pulse (repeat disabled).
REQ-032 rst=1 for one cycle while PRESSED with key_n=0 held -> outputs 0 after that edge, no release_pulse, press_pulse again 6 cycles after rst deasserts.
REQ-033 With KEY_DEBOUNCER_REPEAT_EN, key held 20 cycles past initial press_pulse at cycle T -> press_pulse at T, T+8, T+11, T+14, T+17, T+20.

Source files
------------

// File: rtl/key_debouncer.sv
// key_debouncer
//   Debounces an active-low, bouncy pushbutton. The raw key is brought into
//   the clk domain through a 2-flop synchronizer and inverted. A 4-state FSM
//   then accepts a level change only after DEBOUNCE_CYCLES consecutive stable
//   synchronized cycles.
//
//   Optional feature: define KEY_DEBOUNCER_REPEAT_EN to add auto-repeat. While
//   the key stays held, press_pulse fires again REPEAT_DELAY cycles after the
//   initial press_pulse, then every REPEAT_PERIOD cycles. Without the macro
//   there is no repeat logic and REPEAT_DELAY/REPEAT_PERIOD are unused.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous reset, active-high
//   key_n         in   raw asynchronous key, active-low
//   press         out  debounced key level, active-high
//   press_pulse   out  one-cycle strobe on each accepted press (and repeat)
//   release_pulse out  one-cycle strobe on each accepted release
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    // Elaboration-time guard on illegal parameter values.
    if (DEBOUNCE_CYCLES < 1 || REPEAT_PERIOD < 1 ||
        REPEAT_DELAY + REPEAT_PERIOD < REPEAT_PERIOD) begin : g_bad_params
        $error("key_debouncer: illegal parameter values");
    end

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // Synchronizer stores the inverted key so reset value 0 means released.
    logic            sync1_q, sync2_q;
    logic            raw_s;
    logic            press_q, press_d;
    logic            ppulse_q, ppulse_d;
    logic            rpulse_q, rpulse_d;

`ifdef KEY_DEBOUNCER_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_WRAP  = RW'(REPEAT_DELAY + REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] RPT_BASE  = RW'(REPEAT_DELAY);
    logic [RW-1:0]   rpt_q, rpt_d;
`endif

    assign raw_s = sync2_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ppulse_d = 1'b0;
        rpulse_d = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (raw_s) begin
                    state_d = PRESS_PEND;
                    cnt_d   = '0;
                end
            end
            PRESS_PEND: begin
                if (!raw_s) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = PRESSED;
                    ppulse_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!raw_s) begin
                    state_d = RELEASE_PEND;
                    cnt_d   = '0;
                end
            end
            RELEASE_PEND: begin
                if (raw_s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = RELEASED;
                    rpulse_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RELEASED;
        endcase

`ifdef KEY_DEBOUNCER_REPEAT_EN
        // Counter value k means k cycles since the initial press_pulse; after
        // the first repeat it cycles RPT_BASE..RPT_WRAP, firing at each wrap.
        rpt_d = rpt_q;
        if (state_q == PRESS_PEND && state_d == PRESSED) begin
            rpt_d = '0;
        end else if (state_q == PRESSED && state_d == PRESSED) begin
            if (rpt_q == RPT_WRAP) begin
                rpt_d    = RPT_BASE;
                ppulse_d = 1'b1;
            end else begin
                if (rpt_q == RPT_FIRST) begin
                    ppulse_d = 1'b1;
                end
                rpt_d = rpt_q + 1'b1;
            end
        end else if (state_q == RELEASED) begin
            rpt_d = '0;
        end
`endif

        press_d = (state_d == PRESSED) || (state_d == RELEASE_PEND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= RELEASED;
            cnt_q    <= '0;
            press_q  <= 1'b0;
            ppulse_q <= 1'b0;
            rpulse_q <= 1'b0;
`ifdef KEY_DEBOUNCER_REPEAT_EN
            rpt_q    <= '0;
`endif
        end else begin
            sync1_q  <= ~key_n;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
            ppulse_q <= ppulse_d;
            rpulse_q <= rpulse_d;
`ifdef KEY_DEBOUNCER_REPEAT_EN
            rpt_q    <= rpt_d;
`endif
        end
    end

    assign press         = press_q;
    assign press_pulse   = ppulse_q;
    assign release_pulse = rpulse_q;

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer
//   Directed self-checking bench for key_debouncer with DEBOUNCE_CYCLES=4,
//   REPEAT_DELAY=8, REPEAT_PERIOD=3. Expectations follow the latency rule:
//   with key_n first sampled low at edge N, press/press_pulse rise after
//   edge N+6.
module tb_key_debouncer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_n = 1'b1;
    logic press, press_pulse, release_pulse;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef KEY_DEBOUNCER_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    key_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_n         (key_n),
        .press         (press),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        key_n = 1'b1;
        tick(2);
        n_checks++;
        if (press !== 1'b0) begin n_fail++; $display("FAIL reset_press got=%b exp=0", press); end
        n_checks++;
        if (press_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_ppulse got=%b exp=0", press_pulse); end
        n_checks++;
        if (release_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_rpulse got=%b exp=0", release_pulse); end
        rst = 1'b0;
        tick(3);
    endtask

    task automatic test_press();
        key_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            n_checks++;
            if (press !== 1'b0 || press_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL press_early edge=N+%0d press=%b ppulse=%b exp=0,0", k, press, press_pulse);
            end
        end
        tick(1);
        n_checks++;
        if (press !== 1'b1 || press_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL press_rise press=%b ppulse=%b exp=1,1", press, press_pulse);
        end
        tick(1);
        n_checks++;
        if (press !== 1'b1 || press_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL press_hold press=%b ppulse=%b exp=1,0", press, press_pulse);
        end
    endtask

    task automatic test_glitch_pressed();
        key_n = 1'b1;
        tick(2);
        key_n = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            n_checks++;
            if (press !== 1'b1 || release_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_pressed cyc=%0d press=%b rpulse=%b exp=1,0", k, press, release_pulse);
            end
`ifndef KEY_DEBOUNCER_REPEAT_EN
            n_checks++;
            if (press_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_ppulse cyc=%0d got=%b exp=0", k, press_pulse);
            end
`endif
        end
    endtask

    task automatic test_release();
        key_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            n_checks++;
            if (press !== 1'b1 || release_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL release_early edge=N+%0d press=%b rpulse=%b exp=1,0", k, press, release_pulse);
            end
        end
        tick(1);
        n_checks++;
        if (press !== 1'b0 || release_pulse !== 1'b1 || press_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL release_fall press=%b rpulse=%b ppulse=%b exp=0,1,0", press, release_pulse, press_pulse);
        end
        tick(1);
        n_checks++;
        if (press !== 1'b0 || release_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL release_after press=%b rpulse=%b exp=0,0", press, release_pulse);
        end
    endtask

    task automatic test_bounce();
        // key_n per cycle: low 3, high 1, low 2, then high.
        logic [15:0] pat;
        pat = 16'b1111_1111_1100_1000;
        for (int k = 0; k < 16; k++) begin
            key_n = pat[k];
            tick(1);
            n_checks++;
            if (press !== 1'b0 || press_pulse !== 1'b0 || release_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce cyc=%0d press=%b ppulse=%b rpulse=%b exp=0,0,0",
                         k, press, press_pulse, release_pulse);
            end
        end
    endtask

    task automatic test_repeat();
        logic exp_pp;
        key_n = 1'b0;
        tick(6);
        tick(1);
        n_checks++;
        if (press_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL repeat_initial ppulse=%b exp=1", press_pulse);
        end
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            exp_pp = REP && (k == 8 || k == 11 || k == 14 || k == 17 || k == 20);
            n_checks++;
            if (press_pulse !== exp_pp || press !== 1'b1 || release_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL repeat T+%0d ppulse=%b exp=%b press=%b rpulse=%b",
                         k, press_pulse, exp_pp, press, release_pulse);
            end
        end
    endtask

    task automatic test_reset_pressed();
        key_n = 1'b0;
        rst   = 1'b1;
        tick(1);
        rst = 1'b0;
        n_checks++;
        if (press !== 1'b0 || press_pulse !== 1'b0 || release_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pressed_out press=%b ppulse=%b rpulse=%b exp=0,0,0",
                     press, press_pulse, release_pulse);
        end
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            n_checks++;
            if (press !== 1'b0 || press_pulse !== 1'b0 || release_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_redebounce R+%0d press=%b ppulse=%b rpulse=%b exp=0,0,0",
                         k, press, press_pulse, release_pulse);
            end
        end
        tick(1);
        n_checks++;
        if (press !== 1'b1 || press_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_repress press=%b ppulse=%b exp=1,1", press, press_pulse);
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch_pressed();
        test_release();
        test_bounce();
        test_repeat();
        test_reset_pressed();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
